// File: rtl/activity_gate_ctrl_pkg.sv
// Shared types and helpers for the activity/clock-gate controller.
package activity_pkg;

  // Per-channel clock-gate handshake states.
  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    GATE_REQ = 2'd1,
    GATED    = 2'd2,
    WAKE_REQ = 2'd3
  } ch_state_e;

  // Saturating increment. Operands are carried at 64 bits so that one helper
  // serves any counter width up to 64. The caller narrows the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input logic [63:0] max_value);
    logic [63:0] result;
    if (value >= max_value) begin
      result = max_value;
    end else begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/activity_gate_ch.sv
// One channel: saturating idle counter, recent-activity window and the
// four-phase clock-gate request/acknowledge FSM. All outputs are registers.
module activity_gate_ch
  import activity_pkg::*;
#(
  parameter int W     = 16,
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             activity_pulse,
  input  logic             periph_en,
  input  logic [W-1:0]     idle_thresh,
  input  logic [WIN_W-1:0] activity_window,
  input  logic             gate_ack,
  output logic [W-1:0]     idle_count,
  output logic             recent_activity,
  output logic             gate_req,
  output logic             gated,
  output logic             wake_irq
);

  localparam logic [W-1:0] CNT_ONES = {W{1'b1}};

  logic [W-1:0]     cnt_r;
  logic [W-1:0]     cnt_next;
  logic [WIN_W-1:0] win_r;
  logic [WIN_W-1:0] win_next;
  ch_state_e        state_r;
  ch_state_e        state_next;
  logic             wake_next;
  logic             recent_r;
  logic             gate_req_r;
  logic             gated_r;
  logic             wake_irq_r;

  // Idle counter next value: clear on disable or activity, else saturate upward.
  always_comb begin
    cnt_next = cnt_r;
    if (!periph_en) begin
      cnt_next = {W{1'b0}};
    end else if (activity_pulse) begin
      cnt_next = {W{1'b0}};
    end else begin
      cnt_next = W'(sat_inc(64'(cnt_r), 64'(CNT_ONES)));
    end
  end

  // Window counter next value: reload on every pulse, count down to zero.
  always_comb begin
    win_next = win_r;
    if (!periph_en) begin
      win_next = {WIN_W{1'b0}};
    end else if (activity_pulse) begin
      win_next = activity_window;
    end else if (win_r != {WIN_W{1'b0}}) begin
      win_next = win_r - {{(WIN_W-1){1'b0}}, 1'b1};
    end else begin
      win_next = win_r;
    end
  end

  // Handshake FSM next state; an abort in GATE_REQ beats a same-cycle ack,
  // and only an activity-caused exit from GATED raises the wake interrupt.
  always_comb begin
    state_next = state_r;
    wake_next  = 1'b0;
    case (state_r)
      ACTIVE: begin
        if (periph_en && (idle_thresh != {W{1'b0}}) &&
            (cnt_r >= idle_thresh) && !activity_pulse) begin
          state_next = GATE_REQ;
        end else begin
          state_next = ACTIVE;
        end
      end
      GATE_REQ: begin
        if (activity_pulse || !periph_en) begin
          state_next = WAKE_REQ;
        end else if (gate_ack) begin
          state_next = GATED;
        end else begin
          state_next = GATE_REQ;
        end
      end
      GATED: begin
        if (activity_pulse || !periph_en) begin
          state_next = WAKE_REQ;
          wake_next  = activity_pulse;
        end else begin
          state_next = GATED;
        end
      end
      WAKE_REQ: begin
        if (!gate_ack) begin
          state_next = ACTIVE;
        end else begin
          state_next = WAKE_REQ;
        end
      end
      default: begin
        state_next = ACTIVE;
      end
    endcase
  end

  // State, counters and registered output decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ACTIVE;
      cnt_r      <= {W{1'b0}};
      win_r      <= {WIN_W{1'b0}};
      recent_r   <= 1'b0;
      gate_req_r <= 1'b0;
      gated_r    <= 1'b0;
      wake_irq_r <= 1'b0;
    end else begin
      state_r    <= state_next;
      cnt_r      <= cnt_next;
      win_r      <= win_next;
      recent_r   <= (win_next != {WIN_W{1'b0}});
      gate_req_r <= (state_next == GATE_REQ) || (state_next == GATED);
      gated_r    <= (state_next == GATED);
      wake_irq_r <= wake_next;
    end
  end

  assign idle_count      = cnt_r;
  assign recent_activity = recent_r;
  assign gate_req        = gate_req_r;
  assign gated           = gated_r;
  assign wake_irq        = wake_irq_r;

endmodule

// File: rtl/activity_gate_ctrl.sv
// N-channel activity monitor and clock-gate request controller. Each channel
// is independent; only the activity window length is shared.
module activity_gate_ctrl
  import activity_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int WIN_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       activity_pulse,
  input  logic [N-1:0]       periph_en,
  input  logic [N*W-1:0]     idle_thresh,
  input  logic [WIN_W-1:0]   activity_window,
  input  logic [N-1:0]       gate_ack,
  output logic [N*W-1:0]     idle_count,
  output logic [N-1:0]       recent_activity,
  output logic [N-1:0]       gate_req,
  output logic [N-1:0]       gated,
  output logic [N-1:0]       wake_irq
);

  // Per-channel idle counters, kept as a named array for hierarchical access.
  logic [W-1:0] idle_counter [N];

  for (genvar g = 0; g < N; g++) begin : g_ch
    activity_gate_ch #(
      .W     (W),
      .WIN_W (WIN_W)
    ) u_ch (
      .clk             (clk),
      .rst_n           (rst_n),
      .activity_pulse  (activity_pulse[g]),
      .periph_en       (periph_en[g]),
      .idle_thresh     (idle_thresh[g*W +: W]),
      .activity_window (activity_window),
      .gate_ack        (gate_ack[g]),
      .idle_count      (idle_counter[g]),
      .recent_activity (recent_activity[g]),
      .gate_req        (gate_req[g]),
      .gated           (gated[g]),
      .wake_irq        (wake_irq[g])
    );

    assign idle_count[g*W +: W] = idle_counter[g];
  end

endmodule

// File: tb/tb_activity_gate_ctrl.sv
// Self-checking bench for activity_gate_ctrl: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
module tb_activity_gate_ctrl;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int WIN_W = 4;
  localparam int S_ACT = 0, S_REQ = 1, S_GTD = 2, S_WAK = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       activity_pulse;
  logic [N-1:0]       periph_en;
  logic [N*W-1:0]     idle_thresh;
  logic [WIN_W-1:0]   activity_window;
  logic [N-1:0]       gate_ack;
  logic [N*W-1:0]     idle_count;
  logic [N-1:0]       recent_activity;
  logic [N-1:0]       gate_req;
  logic [N-1:0]       gated;
  logic [N-1:0]       wake_irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model state per channel.
  int m_cnt [N];
  int m_win [N];
  int m_st  [N];
  bit m_irq [N];

  activity_gate_ctrl #(.N(N), .W(W), .WIN_W(WIN_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .activity_pulse  (activity_pulse),
    .periph_en       (periph_en),
    .idle_thresh     (idle_thresh),
    .activity_window (activity_window),
    .gate_ack        (gate_ack),
    .idle_count      (idle_count),
    .recent_activity (recent_activity),
    .gate_req        (gate_req),
    .gated           (gated),
    .wake_irq        (wake_irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0; m_win[c] = 0; m_st[c] = S_ACT; m_irq[c] = 1'b0;
    end
  endtask

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      bit en, p, ack;
      int thr;
      en  = periph_en[c];
      p   = activity_pulse[c];
      ack = gate_ack[c];
      thr = int'(idle_thresh[c*W +: W]);
      m_irq[c] = 1'b0;
      if (m_st[c] == S_ACT) begin
        if (en && thr != 0 && m_cnt[c] >= thr && !p) m_st[c] = S_REQ;
      end else if (m_st[c] == S_REQ) begin
        if (p || !en) m_st[c] = S_WAK;
        else if (ack) m_st[c] = S_GTD;
      end else if (m_st[c] == S_GTD) begin
        if (p || !en) begin m_st[c] = S_WAK; m_irq[c] = p; end
      end else begin
        if (!ack) m_st[c] = S_ACT;
      end
      if (!en || p) m_cnt[c] = 0;
      else if (m_cnt[c] < 65535) m_cnt[c] = m_cnt[c] + 1;
      if (!en) m_win[c] = 0;
      else if (p) m_win[c] = int'(activity_window);
      else if (m_win[c] > 0) m_win[c] = m_win[c] - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; activity_pulse = '0; periph_en = '0; idle_thresh = '0;
    activity_window = '0; gate_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({idle_count, recent_activity, gate_req, gated, wake_irq} !== '0)
      $display("FAIL reset_outputs: got cnt=%h ra=%b req=%b gtd=%b irq=%b want all 0",
               idle_count, recent_activity, gate_req, gated, wake_irq);
    else pass_cnt++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_count();
    periph_en = 4'b0001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      total_cnt++;
      if (idle_count[15:0] !== 16'(e) || idle_count[63:16] !== 48'd0 || gate_req !== 4'b0)
        $display("FAIL ch0_count edge %0d: got cnt=%h req=%b want cnt0=%0d others 0 req=0",
                 e, idle_count, gate_req, e);
      else pass_cnt++;
    end
    periph_en = 4'b0000;
    tick();
  endtask

  task automatic test_gate();
    idle_thresh[31:16] = 16'd5;
    periph_en = 4'b0010;
    repeat (5) tick();
    total_cnt++;
    if (idle_count[31:16] !== 16'd5 || gate_req[1] !== 1'b0)
      $display("FAIL gate_thresh_reach: got cnt=%0d req=%b want 5 0", idle_count[31:16], gate_req[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (gate_req[1] !== 1'b1 || gated[1] !== 1'b0)
      $display("FAIL gate_req_rise: got req=%b gtd=%b want 1 0", gate_req[1], gated[1]);
    else pass_cnt++;
    gate_ack[1] = 1'b1;
    tick();
    total_cnt++;
    if (gated[1] !== 1'b1 || gate_req[1] !== 1'b1)
      $display("FAIL gate_ack_gated: got gtd=%b req=%b want 1 1", gated[1], gate_req[1]);
    else pass_cnt++;
  endtask

  task automatic test_wake_and_abort();
    // Wake from GATED by activity.
    activity_pulse[1] = 1'b1;
    tick();
    activity_pulse[1] = 1'b0;
    total_cnt++;
    if (gate_req[1] !== 1'b0 || gated[1] !== 1'b0 || wake_irq[1] !== 1'b1 || idle_count[31:16] !== 16'd0)
      $display("FAIL wake_edge: got req=%b gtd=%b irq=%b cnt=%0d want 0 0 1 0",
               gate_req[1], gated[1], wake_irq[1], idle_count[31:16]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (wake_irq[1] !== 1'b0 || gate_req[1] !== 1'b0)
      $display("FAIL wake_irq_single: got irq=%b req=%b want 0 0", wake_irq[1], gate_req[1]);
    else pass_cnt++;
    gate_ack[1] = 1'b0;
    // No re-request until the count reaches 5 again.
    for (int i = 0; i < 20 && idle_count[31:16] < 16'd5; i++) begin
      tick();
      total_cnt++;
      if (gate_req[1] !== 1'b0)
        $display("FAIL no_early_rereq: got req=%b at cnt=%0d want 0", gate_req[1], idle_count[31:16]);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (gate_req[1] !== 1'b1)
      $display("FAIL rereq: got req=%b want 1", gate_req[1]);
    else pass_cnt++;
    // Abort from GATE_REQ without ack.
    activity_pulse[1] = 1'b1;
    tick();
    activity_pulse[1] = 1'b0;
    total_cnt++;
    if (gate_req[1] !== 1'b0 || wake_irq[1] !== 1'b0)
      $display("FAIL abort_no_ack: got req=%b irq=%b want 0 0", gate_req[1], wake_irq[1]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (gate_req[1] !== 1'b0 || gated[1] !== 1'b0)
      $display("FAIL abort_to_active: got req=%b gtd=%b want 0 0", gate_req[1], gated[1]);
    else pass_cnt++;
    for (int i = 0; i < 20 && !gate_req[1]; i++) tick();
    total_cnt++;
    if (gate_req[1] !== 1'b1)
      $display("FAIL rereq_after_abort: got req=%b want 1", gate_req[1]);
    else pass_cnt++;
    // Abort and ack in the same cycle: abort wins.
    activity_pulse[1] = 1'b1;
    gate_ack[1] = 1'b1;
    tick();
    activity_pulse[1] = 1'b0;
    total_cnt++;
    if (gate_req[1] !== 1'b0 || gated[1] !== 1'b0 || wake_irq[1] !== 1'b0)
      $display("FAIL abort_beats_ack: got req=%b gtd=%b irq=%b want 0 0 0",
               gate_req[1], gated[1], wake_irq[1]);
    else pass_cnt++;
    tick();
    gate_ack[1] = 1'b0;
    tick();
    periph_en[1] = 1'b0;
    idle_thresh[31:16] = 16'd0;
    tick();
  endtask

  task automatic test_window();
    bit exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    periph_en[3] = 1'b1;
    activity_window = 4'd3;
    activity_pulse[3] = 1'b1;
    tick();
    activity_pulse[3] = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      if (e > 1) tick();
      total_cnt++;
      if (recent_activity[3] !== (e <= 3))
        $display("FAIL window_len edge %0d: got %b want %b", e, recent_activity[3], e <= 3);
      else pass_cnt++;
    end
    // Re-pulse at edge 2 extends the window.
    activity_pulse[3] = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      activity_pulse[3] = (e == 1);
      total_cnt++;
      if (recent_activity[3] !== exp_seq[e])
        $display("FAIL window_repulse step %0d: got %b want %b", e, recent_activity[3], exp_seq[e]);
      else pass_cnt++;
    end
    activity_window = 4'd0;
    activity_pulse[3] = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      activity_pulse[3] = 1'b0;
      total_cnt++;
      if (recent_activity[3] !== 1'b0)
        $display("FAIL window_zero step %0d: got %b want 0", e, recent_activity[3]);
      else pass_cnt++;
    end
    periph_en[3] = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    periph_en[2] = 1'b1;
    activity_window = 4'd5;
    for (int e = 1; e <= 65537; e++) begin
      tick();
      if (e == 65530 || e >= 65535) begin
        logic [15:0] want;
        want = (e == 65530) ? 16'hFFFA : 16'hFFFF;
        total_cnt++;
        if (idle_count[47:32] !== want)
          $display("FAIL saturate edge %0d: got %h want %h", e, idle_count[47:32], want);
        else pass_cnt++;
      end
    end
    idle_thresh[47:32] = 16'hFFFF;
    tick();
    gate_ack[2] = 1'b1;
    tick();
    total_cnt++;
    if (gated[2] !== 1'b1)
      $display("FAIL sat_gate_full_thresh: got gtd=%b want 1", gated[2]);
    else pass_cnt++;
    periph_en[2] = 1'b0;
    tick();
    total_cnt++;
    if (gate_req[2] !== 1'b0 || gated[2] !== 1'b0 || wake_irq[2] !== 1'b0 ||
        idle_count[47:32] !== 16'd0 || recent_activity[2] !== 1'b0)
      $display("FAIL disable_wake: got req=%b gtd=%b irq=%b cnt=%h ra=%b want 0 0 0 0 0",
               gate_req[2], gated[2], wake_irq[2], idle_count[47:32], recent_activity[2]);
    else pass_cnt++;
    gate_ack[2] = 1'b0;
    idle_thresh[47:32] = 16'd0;
    tick();
  endtask

  task automatic test_reset_mid_handshake();
    idle_thresh[15:0] = 16'd2;
    periph_en[0] = 1'b1;
    for (int i = 0; i < 10 && !gate_req[0]; i++) tick();
    gate_ack[0] = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (gate_req[0] !== 1'b0 || wake_irq !== 4'b0 || idle_count !== '0)
      $display("FAIL reset_mid_handshake: got req=%b irq=%b cnt=%h want 0 0 0",
               gate_req[0], wake_irq, idle_count);
    else pass_cnt++;
    gate_ack = '0; periph_en = '0; idle_thresh = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 31) == 0) periph_en[c] = ~periph_en[c];
        activity_pulse[c] = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 63) == 0) idle_thresh[c*W +: W] = 16'($urandom_range(0, 12));
        if (gate_ack[c] != gate_req[c] && $urandom_range(0, 1) == 1) gate_ack[c] = gate_req[c];
      end
      if ($urandom_range(0, 99) == 0) activity_window = 4'($urandom_range(0, 15));
      tick();
      for (int c = 0; c < N; c++) begin
        bit e_req, e_gtd, e_ra;
        e_req = (m_st[c] == S_REQ) || (m_st[c] == S_GTD);
        e_gtd = (m_st[c] == S_GTD);
        e_ra  = (m_win[c] != 0);
        total_cnt++;
        if (idle_count[c*W +: W] !== 16'(m_cnt[c]) || gate_req[c] !== e_req || gated[c] !== e_gtd ||
            wake_irq[c] !== m_irq[c] || recent_activity[c] !== e_ra)
          $display("FAIL random cyc %0d ch %0d: got cnt=%0d req=%b gtd=%b irq=%b ra=%b want %0d %b %b %b %b",
                   cyc, c, idle_count[c*W +: W], gate_req[c], gated[c], wake_irq[c], recent_activity[c],
                   m_cnt[c], e_req, e_gtd, m_irq[c], e_ra);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_gate();
    test_wake_and_abort();
    test_window();
    test_saturate();
    test_reset_mid_handshake();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/activity_gate_ctrl.md
Name: activity_gate_ctrl

Overview:
Parametrised successor to the per-peripheral activity counter. Each of N channels keeps:
- a saturating W-bit idle counter;
- a recent-activity window whose length is set at run time;
- a per-channel idle threshold that drives a four-phase clock-gate request/acknowledge handshake with the power controller.

The block sits between the peripheral activity sources and the power/clock-gating controller. It raises wake_irq when a gated channel sees activity.

Parameters:
- N, 4, number of peripheral channels.
- W, 16, idle counter and threshold width.
- WIN_W, 4, width of the activity-window counter and of the activity_window input.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- activity_pulse, input, N, per-channel activity strobe, sampled each posedge.
- periph_en, input, N, per-channel enable.
- idle_thresh, input, N x W, per-channel gate threshold; 0 disables gating for that channel.
- activity_window, input, WIN_W, shared recent-activity window length in cycles.
- gate_ack, input, N, power-controller acknowledge, level signal.
- idle_count, output, N x W, registered idle cycle count.
- recent_activity, output, N, high while the channel's window counter is nonzero.
- gate_req, output, N, request to gate the channel clock, level signal.
- gated, output, N, high while the channel is in GATED.
- wake_irq, output, N, one-cycle pulse on activity-driven wake from GATED.

Behaviour:
- Reset: asynchronous on rst_n low. All outputs 0, all counters 0, every channel FSM in ACTIVE. Assert mid-handshake: gate_req drops immediately; no wake_irq is generated.
- Idle counter, per posedge, first match wins:
  - periph_en=0: counter <= 0.
  - activity_pulse=1: counter <= 0.
  - counter != all-ones: counter <= counter + 1.
  - otherwise: hold at 2^W-1 (saturation, no wrap).
  - idle_count is the register itself, so the value is visible one edge after the event. The counter runs in every FSM state.
- Window counter (WIN_W bits):
  - periph_en=0: cleared to 0.
  - activity_pulse=1: loaded with activity_window; a pulse during the window reloads it.
  - otherwise: decremented if nonzero.
  - recent_activity = (window counter != 0). A pulse therefore gives exactly activity_window high cycles. activity_window=0 means recent_activity never asserts.
- Channel FSM states: ACTIVE, GATE_REQ, GATED, WAKE_REQ.
  - ACTIVE -> GATE_REQ when periph_en=1, idle_thresh!=0, idle_count>=idle_thresh and activity_pulse=0.
  - GATE_REQ:
    - activity_pulse=1 or periph_en=0 -> WAKE_REQ (abort). This takes priority over a simultaneous gate_ack.
    - else gate_ack=1 -> GATED.
  - GATED: activity_pulse=1 or periph_en=0 -> WAKE_REQ. wake_irq pulses high for the cycle after the edge only when the cause is activity_pulse.
  - WAKE_REQ: gate_ack=0 -> ACTIVE; otherwise wait indefinitely.
- Output decode, registered state, Moore outputs:
  - gate_req = state in {GATE_REQ, GATED}.
  - gated = (state == GATED).
- Handshake is four-phase: req up, ack up, req down, ack down. gate_req never re-rises before gate_ack has been seen low in WAKE_REQ.
- The threshold compare is unsigned, full W bits. Changing idle_thresh while in GATE_REQ or GATED has no effect until the channel returns to ACTIVE.
- Channels are fully independent. Simultaneous events on different channels do not interact.

Decomposition:
- Package activity_pkg holds:
  - the ch_state_e enum (ACTIVE=2'd0, GATE_REQ=2'd1, GATED=2'd2, WAKE_REQ=2'd3);
  - a saturating-increment helper function.
- Sub-module activity_gate_ch implements one channel (counters plus FSM). The top level generates N instances and shares activity_window.
- Internal counter array is named idle_counter[N] so the bench can force it.

Test Plan:
- Reset, then periph_en[0]=1 with idle_thresh[0]=0 -> idle_count[0]=1..10 on edges 1..10; gate_req[0] stays 0; all other channels stay 0.
- idle_thresh[1]=5, periph_en[1]=1 -> idle_count[1]=5 after edge 5; gate_req[1]=1 after edge 6. gate_ack[1]=1 -> gated[1]=1 next edge.
- Channel 1 GATED, activity_pulse[1] for 1 cycle -> next edge gate_req[1]=0, gated[1]=0, wake_irq[1]=1 for exactly 1 cycle, idle_count[1]=0. Drop gate_ack -> ACTIVE one edge later, and no re-request until idle_count reaches 5 again.
- Abort: channel in GATE_REQ with gate_ack=0, pulse -> gate_req drops next edge with wake_irq=0, back in ACTIVE one edge later. Repeat with gate_ack and pulse in the same cycle -> abort wins.
- activity_window=3, pulse on channel 3 -> recent_activity[3]=1 for 3 edges then 0. A repulse at edge 2 extends it to 3 more. activity_window=0 -> recent_activity never asserts.
- Force idle_counter[2]=16'hFFFA -> reaches 16'hFFFF after 5 edges and holds for 2 more. Then, with channel 2 gated, periph_en[2]=0 -> WAKE_REQ, wake_irq[2]=0, idle_count[2]=0, recent_activity[2]=0.
